// File: rtl/rand_draw_arbiter_pkg.sv
// Shared definitions for the random-draw arbiter: FSM encoding and LFSR constants.
package rand_draw_arbiter_pkg;

   localparam int unsigned LFSR_W = 20;
   localparam int unsigned TAP_HI = 19;
   localparam int unsigned TAP_LO = 16;
   localparam logic [LFSR_W-1:0] LFSR_ONES = 20'hFFFFF;
   localparam int unsigned SHIFTS_PER_STEP = 8;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StDraw = 2'd1,
      StResp = 2'd2,
      StLoad = 2'd3
   } state_e;

   // One Fibonacci shift of x^20 + x^17 + 1, shifting left.
   function automatic logic [LFSR_W-1:0] lfsr_shift(input logic [LFSR_W-1:0] l);
      return {l[LFSR_W-2:0], l[TAP_HI] ^ l[TAP_LO]};
   endfunction

endpackage

// File: rtl/rng_lfsr20_step8.sv
// 20-bit LFSR register advancing eight shifts per step; a load overrides a step.
module rng_lfsr20_step8
   import rand_draw_arbiter_pkg::*;
#(
   parameter int unsigned OUT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic [OUT_W-1:0]  value
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] stepped;

   always_comb begin
      stepped = lfsr_q;
      for (int unsigned i = 0; i < SHIFTS_PER_STEP; i++) begin
         stepped = lfsr_shift(stepped);
      end
   end

   always_comb begin
      lfsr_d = lfsr_q;
      if (load) begin
         lfsr_d = load_val;
      end else if (step) begin
         lfsr_d = stepped;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr_q <= LFSR_ONES;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/rand_draw_arbiter.sv
// Round-robin arbiter sharing one LFSR among requesters, with bounded draws via
// rejection sampling and deferred reseeding.
module rand_draw_arbiter
   import rand_draw_arbiter_pkg::*;
#(
   parameter int unsigned NREQ    = 6,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned MAX_TRY = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*DATA_W-1:0] req_limit,
   output logic [NREQ-1:0]        rsp_valid,
   input  logic [NREQ-1:0]        rsp_ready,
   output logic [DATA_W-1:0]      rsp_data,
   output logic                   rsp_fallback,
   input  logic                   reseed_req,
   input  logic [LFSR_W-1:0]      seed,
   output logic                   reseed_done,
   output logic                   busy
);

   localparam int unsigned ID_W = $clog2(NREQ);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     gnt_q, gnt_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [DATA_W-1:0]   lim_q, lim_d;
   logic [3:0]          try_cnt_q, try_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                fallback_q, fallback_d;
   logic [LFSR_W-1:0]   seed_q, seed_d;
   logic                reseed_pend_q, reseed_pend_d;

   logic                lfsr_load;
   logic                lfsr_step;
   logic [LFSR_W-1:0]   load_val;
   logic [DATA_W-1:0]   cand;

   logic [DATA_W-1:0]   limits [NREQ];
   logic                win_found;
   logic [ID_W-1:0]     win_id;
   logic [ID_W-1:0]     scan_id;
   int unsigned         scan_idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_limits
      assign limits[g] = req_limit[g*DATA_W +: DATA_W];
   end

   rng_lfsr20_step8 #(
      .OUT_W (DATA_W)
   ) u_lfsr (
      .clk      (clk),
      .rst      (rst),
      .load     (lfsr_load),
      .load_val (load_val),
      .step     (lfsr_step),
      .value    (cand)
   );

   // An all-zero LFSR would lock up, so a zero seed is remapped.
   assign load_val = (seed_q == '0) ? LFSR_ONES : seed_q;

   // First requester at or after rr_ptr, wrapping.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      scan_idx  = 0;
      scan_id   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         scan_idx = 32'(rr_ptr_q) + i;
         if (scan_idx >= NREQ) begin
            scan_idx = scan_idx - NREQ;
         end
         scan_id = scan_idx[ID_W-1:0];
         if (!win_found && req[scan_id]) begin
            win_found = 1'b1;
            win_id    = scan_id;
         end
      end
   end

   // A new pulse in the LOAD cycle stays pending so it is not lost.
   always_comb begin
      seed_d        = reseed_req ? seed : seed_q;
      reseed_pend_d = reseed_req | (reseed_pend_q & (state_q != StLoad));
   end

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      rr_ptr_d    = rr_ptr_q;
      lim_d       = lim_q;
      try_cnt_d   = try_cnt_q;
      data_d      = data_q;
      fallback_d  = fallback_q;
      lfsr_load   = 1'b0;
      lfsr_step   = 1'b0;
      reseed_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (reseed_pend_q) begin
               state_d = StLoad;
            end else if (win_found) begin
               gnt_d     = win_id;
               lim_d     = limits[win_id];
               lfsr_step = 1'b1;
               try_cnt_d = '0;
               state_d   = StDraw;
            end
         end
         StDraw: begin
            if ((lim_q == '0) || (cand < lim_q)) begin
               data_d     = cand;
               fallback_d = 1'b0;
               state_d    = StResp;
            end else if (try_cnt_q == 4'(MAX_TRY - 1)) begin
               data_d     = '0;
               fallback_d = 1'b1;
               state_d    = StResp;
            end else begin
               lfsr_step = 1'b1;
               try_cnt_d = try_cnt_q + 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready[gnt_q]) begin
               rr_ptr_d = (gnt_q == ID_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
               state_d  = StIdle;
            end
         end
         StLoad: begin
            lfsr_load   = 1'b1;
            reseed_done = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= StIdle;
         gnt_q         <= '0;
         rr_ptr_q      <= '0;
         lim_q         <= '0;
         try_cnt_q     <= '0;
         data_q        <= '0;
         fallback_q    <= 1'b0;
         seed_q        <= '0;
         reseed_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         gnt_q         <= gnt_d;
         rr_ptr_q      <= rr_ptr_d;
         lim_q         <= lim_d;
         try_cnt_q     <= try_cnt_d;
         data_q        <= data_d;
         fallback_q    <= fallback_d;
         seed_q        <= seed_d;
         reseed_pend_q <= reseed_pend_d;
      end
   end

   assign rsp_valid    = (state_q == StResp) ? (NREQ'(1) << gnt_q) : '0;
   assign rsp_data     = data_q;
   assign rsp_fallback = fallback_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_rand_draw_arbiter.sv
// Directed bench for rand_draw_arbiter: vector table for arbitration and bounded
// draws, plus hand-written reseed, back-pressure and asynchronous-reset sequences.
module tb_rand_draw_arbiter;

   localparam int NREQ    = 6;
   localparam int DATA_W  = 8;
   localparam int MAX_TRY = 4;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [NREQ-1:0]        req;
   logic [NREQ*DATA_W-1:0] req_limit;
   logic [NREQ-1:0]        rsp_valid;
   logic [NREQ-1:0]        rsp_ready;
   logic [DATA_W-1:0]      rsp_data;
   logic                   rsp_fallback;
   logic                   reseed_req;
   logic [19:0]            seed;
   logic                   reseed_done;
   logic                   busy;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [19:0] m_lfsr;

   typedef struct {
      logic [NREQ-1:0]   req;
      int                gnt;
      logic [DATA_W-1:0] lim;
   } vec_t;

   vec_t tbl [19];

   always #5 clk = ~clk;

   rand_draw_arbiter #(
      .NREQ    (NREQ),
      .DATA_W  (DATA_W),
      .MAX_TRY (MAX_TRY)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req          (req),
      .req_limit    (req_limit),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_data     (rsp_data),
      .rsp_fallback (rsp_fallback),
      .reseed_req   (reseed_req),
      .seed         (seed),
      .reseed_done  (reseed_done),
      .busy         (busy)
   );

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [19:0] m_step(input logic [19:0] l);
      logic [19:0] r;
      r = l;
      for (int k = 0; k < 8; k++) r = {r[18:0], r[19] ^ r[16]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference draw: one step on grant, then one step per rejection.
   task automatic model_draw(input logic [7:0] lim, output logic [7:0] d, output logic fb,
                             output int lat);
      logic done;
      done = 1'b0;
      d    = '0;
      fb   = 1'b0;
      lat  = 0;
      m_lfsr = m_step(m_lfsr);
      for (int t = 0; t < MAX_TRY; t++) begin
         if (!done) begin
            if (lim == 0 || m_lfsr[7:0] < lim) begin
               d = m_lfsr[7:0]; fb = 1'b0; lat = 2 + t; done = 1'b1;
            end else if (t == MAX_TRY - 1) begin
               d = '0; fb = 1'b1; lat = 2 + t; done = 1'b1;
            end else begin
               m_lfsr = m_step(m_lfsr);
            end
         end
      end
   endtask

   // Entered in the cycle the FSM sees the request; returns cycles until rsp_valid.
   task automatic wait_valid(output int lat);
      lat = -1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid != 0) begin
            lat = k - 1;
            break;
         end
      end
   endtask

   task automatic set_limits(input int gnt, input logic [7:0] lim);
      for (int i = 0; i < NREQ; i++) begin
         req_limit[i*DATA_W +: DATA_W] = (i == gnt) ? lim : ((lim == 8'd1) ? 8'd0 : 8'd1);
      end
   endtask

   task automatic txn(input string name, input logic [NREQ-1:0] r, input int gnt,
                      input logic [7:0] lim);
      logic [7:0]      ed;
      logic            efb;
      int              elat;
      int              lat;
      logic [NREQ-1:0] oh;
      oh  = 6'b1 << gnt;
      req = r;
      set_limits(gnt, lim);
      model_draw(lim, ed, efb, elat);
      wait_valid(lat);
      chk({name, " latency"}, lat, elat);
      chk({name, " rsp_valid"}, rsp_valid, oh);
      chk({name, " rsp_data"}, rsp_data, ed);
      chk({name, " rsp_fallback"}, rsp_fallback, efb);
      rsp_ready = '1;
      @(posedge clk);
      #1;
      rsp_ready = '0;
      chk({name, " busy after handshake"}, busy, 1'b0);
   endtask

   task automatic do_reset();
      req        = '0;
      rsp_ready  = '0;
      reseed_req = 1'b0;
      rst        = 1'b0;
      m_lfsr     = 20'hFFFFF;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] ed;
      logic       efb;
      int         elat;
      int         lat;
      int         pulses;

      tbl[0]  = '{6'b100001, 0, 8'd0};
      tbl[1]  = '{6'b100001, 5, 8'd0};
      tbl[2]  = '{6'b100001, 0, 8'd0};
      tbl[3]  = '{6'b100001, 5, 8'd0};
      tbl[4]  = '{6'b111111, 0, 8'd0};
      tbl[5]  = '{6'b111111, 1, 8'd0};
      tbl[6]  = '{6'b111111, 2, 8'd0};
      tbl[7]  = '{6'b111111, 3, 8'd0};
      tbl[8]  = '{6'b111111, 4, 8'd0};
      tbl[9]  = '{6'b111111, 5, 8'd0};
      tbl[10] = '{6'b111111, 0, 8'd0};
      tbl[11] = '{6'b000100, 2, 8'd1};
      tbl[12] = '{6'b000100, 2, 8'd1};
      tbl[13] = '{6'b000100, 2, 8'd1};
      tbl[14] = '{6'b111111, 3, 8'd100};
      tbl[15] = '{6'b010000, 4, 8'd200};
      tbl[16] = '{6'b001011, 0, 8'd50};
      tbl[17] = '{6'b001011, 1, 8'd50};
      tbl[18] = '{6'b001011, 3, 8'd0};

      req        = '0;
      req_limit  = '0;
      rsp_ready  = '0;
      reseed_req = 1'b0;
      seed       = '0;
      rst        = 1'b0;
      m_lfsr     = 20'hFFFFF;

      // Reset state
      #12;
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset rsp_fallback", rsp_fallback, 0);
      chk("reset reseed_done", reseed_done, 0);
      chk("reset busy", busy, 0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      txn("first draw", 6'b000001, 0, 8'd0);

      // Arbitration and bounded draws from a fresh reset
      do_reset();
      for (int i = 0; i < 19; i++) begin
         txn($sformatf("vec%0d", i), tbl[i].req, tbl[i].gnt, tbl[i].lim);
      end

      // Reseed with zero requested during RESP is deferred past the handshake
      req = 6'b000001;
      set_limits(0, 8'd0);
      model_draw(8'd0, ed, efb, elat);
      wait_valid(lat);
      chk("reseed0 rsp_data", rsp_data, ed);
      seed       = 20'h0;
      reseed_req = 1'b1;
      @(negedge clk);
      reseed_req = 1'b0;
      @(negedge clk);
      chk("reseed0 deferred reseed_done", reseed_done, 0);
      chk("reseed0 rsp_valid held", rsp_valid, 6'b000001);
      req       = '0;
      rsp_ready = 6'b000001;
      @(posedge clk);
      #1;
      rsp_ready = '0;
      pulses    = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (reseed_done) pulses++;
      end
      chk("reseed0 done pulses", pulses, 1);
      m_lfsr = 20'hFFFFF;
      @(posedge clk);
      #1;
      txn("after seed0", 6'b000001, 0, 8'd0);

      // Reseed pending together with a request in IDLE: LOAD goes first
      req = 6'b000001;
      set_limits(0, 8'd0);
      model_draw(8'd0, ed, efb, elat);
      wait_valid(lat);
      chk("reseed1 rsp_data", rsp_data, ed);
      seed       = 20'h12345;
      reseed_req = 1'b1;
      @(negedge clk);
      reseed_req = 1'b0;
      rsp_ready  = 6'b000001;
      @(posedge clk);
      #1;
      rsp_ready = '0;
      @(negedge clk);
      chk("reseed1 idle busy", busy, 0);
      @(negedge clk);
      chk("reseed1 load reseed_done", reseed_done, 1);
      chk("reseed1 load busy", busy, 1);
      m_lfsr = 20'h12345;
      model_draw(8'd0, ed, efb, elat);
      wait_valid(lat);
      chk("seed12345 rsp_valid", rsp_valid, 6'b000001);
      chk("seed12345 rsp_data", rsp_data, ed);
      req       = '0;
      rsp_ready = 6'b000001;
      @(posedge clk);
      #1;
      rsp_ready = '0;

      // Back-pressure with the request dropped; foreign rsp_ready is ignored
      req = 6'b000010;
      set_limits(1, 8'd0);
      model_draw(8'd0, ed, efb, elat);
      wait_valid(lat);
      chk("hold latency", lat, elat);
      req       = '0;
      rsp_ready = 6'b111101;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("hold%0d rsp_valid", k), rsp_valid, 6'b000010);
         chk($sformatf("hold%0d rsp_data", k), rsp_data, ed);
      end
      rsp_ready = 6'b000010;
      @(posedge clk);
      #1;
      rsp_ready = '0;
      chk("hold release busy", busy, 0);
      txn("rr after hold", 6'b111111, 2, 8'd0);

      // Asynchronous reset during DRAW
      req = 6'b000001;
      set_limits(0, 8'd0);
      @(posedge clk);
      #1;
      chk("pre-reset draw busy", busy, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("reset in draw busy", busy, 0);
      chk("reset in draw rsp_valid", rsp_valid, 0);
      req    = '0;
      m_lfsr = 20'hFFFFF;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      txn("restart rr0", 6'b111111, 0, 8'd0);
      txn("restart second", 6'b000010, 1, 8'd0);

      // Asynchronous reset during RESP, with a reseed pending
      req = 6'b001000;
      set_limits(3, 8'd0);
      model_draw(8'd0, ed, efb, elat);
      wait_valid(lat);
      chk("pre-reset resp rsp_valid", rsp_valid, 6'b001000);
      chk("pre-reset resp rsp_data", rsp_data, ed);
      seed       = 20'h55555;
      reseed_req = 1'b1;
      @(posedge clk);
      #1;
      reseed_req = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("reset in resp rsp_valid", rsp_valid, 0);
      chk("reset in resp rsp_data", rsp_data, 0);
      chk("reset in resp rsp_fallback", rsp_fallback, 0);
      chk("reset in resp busy", busy, 0);
      req    = '0;
      m_lfsr = 20'hFFFFF;
      @(negedge clk);
      rst    = 1'b1;
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         if (reseed_done) pulses++;
      end
      chk("reset cleared reseed", pulses, 0);
      @(posedge clk);
      #1;
      txn("after resp reset", 6'b111111, 0, 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
